softmax_feeder: RTL and testbench
=================================

# softmax_feeder

Drives the softmax stage of the classifier datapath from the fully-connected side. It buffers N logits loaded by the upstream layer and streams them into softmax over the in_ready/start handshake. It then captures the predicted class from max_ready/max, switches softmax into backprop, and collects the N-word error vector into a readable buffer for the upstream layer's weight update.

## Interface
- N, 4, number of classes / logits
- IDX_W, 3, index width (must satisfy 2^IDX_W > N)
- DATA_W, 32, data width, Q16.16 signed fixed point
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ld_valid  in  1  write ld_data into logit[ld_idx]; honoured only in IDLE
- ld_idx  in  IDX_W  logit write index
- ld_data  in  DATA_W  logit value
- go  in  1  one-cycle pulse; starts a pass; honoured only in IDLE
- label_in  in  IDX_W  expected class, latched on accepted go
- err_rd_idx  in  IDX_W  error buffer read address
- err_rd_data  out  DATA_W  err[err_rd_idx], combinational; 0 if index >= N
- busy  out  1  high from accepted go until DONE exits
- done  out  1  one-cycle pulse in DONE
- pred  out  IDX_W  class latched from max
- sf_input  out  DATA_W  logit[sf_input_idx]
- sf_input_idx  out  IDX_W  forward word index
- start  out  1  forward: word valid; backprop: consumer ready
- backprop_ctrl  out  1  0 = forward phase, 1 = backprop phase
- expected_label  out  IDX_W  latched label_in
- in_ready  in  1  softmax can accept a forward word
- max_ready  in  1  softmax argmax valid
- max  in  IDX_W  softmax argmax
- out_ready  in  1  softmax backprop word valid
- out_idx  in  IDX_W  backprop word index
- out_data  in  DATA_W  backprop error word

## Operation
- States: IDLE, FWD_SEND, FWD_GAP, WAIT_MAX, BP_WAIT, BP_ACK, DONE.
- IDLE: start=0, backprop_ctrl=0. Loads are written here. An accepted go does the following: latches label_in, clears idx to 0, sets busy, and moves to FWD_SEND.
- FWD_SEND: start=1, sf_input=logit[idx], sf_input_idx=idx. A word transfers on any edge with in_ready=1.
  - On transfer with idx<N-1: idx+1, go to FWD_GAP.
  - On transfer with idx=N-1: go to WAIT_MAX.
- FWD_GAP: start=0 for exactly one cycle, then FWD_SEND. softmax needs the start deassertion to delimit words.
- WAIT_MAX: start=0. On max_ready=1: pred<=max, backprop_ctrl<=1, go to BP_WAIT. In-ready activity is ignored.
- BP_WAIT: start=0. On out_ready=1: go to BP_ACK.
- BP_ACK: start=1. On each edge with out_ready=1 and out_idx<N: err[out_idx]<=out_data.
  - If out_idx=N-1 on that edge: backprop_ctrl<=0, go to DONE.
  - Words with out_idx>=N are dropped and do not complete the pass.
- DONE: done=1, busy stays 1 this cycle, start=0, then IDLE.
- go or ld_valid outside IDLE is ignored; the logit buffer is not modified mid-pass.
- max_ready pulse arriving outside WAIT_MAX is ignored.
- Error buffer retains values until overwritten by the next pass or reset.

## Timing
- Reset values: all outputs 0; logit and err buffers 0; state IDLE.
- Reset asserted mid-pass aborts immediately: start and backprop_ctrl drop asynchronously.
- go at edge k → start=1 with word 0 visible after edge k.
- With in_ready held high, word i transfers at edge k+1+2i. WAIT_MAX is entered after edge k+2N-1.
- pred and backprop_ctrl update on the edge sampling max_ready=1. BP_WAIT→BP_ACK costs one cycle.
- Backprop throughput is one word per cycle while out_ready stays high.
- done is high the cycle after the edge capturing out_idx=N-1.

## Structure
- Shared package sf_pkg: Q16.16 width constant (32), state encoding, default N/IDX_W.
- The logit and error buffers use one sub-module, sf_regbuf (N×DATA_W register file: one sync write port, one async read, async clear).

## Test plan
- Load logits 0x8000, 0x18F00, 0x29E00, 0x3AD00, go, in_ready always 1 → sf_input sequence matches, transfers at edges 1,3,5,7 after go, start low at 2,4,6.
- in_ready held low 5 cycles during word 2 → sf_input/sf_input_idx held stable, start stays 1, no duplicate or skipped word.
- max_ready with max=3 → pred=3, backprop_ctrl=1 the next cycle; max_ready pulse given in IDLE → pred unchanged.
- Backprop words out_idx 0..3 with data 0xFFFF8000, 0x100, 0x200, 0x300 → err_rd_data returns each; backprop_ctrl=0 and done pulses once after index 3.
- out_idx=5 injected mid-backprop, and go/ld_valid mid-pass → dropped; buffers and state unaffected.
- rst_n low during BP_ACK → all outputs 0 immediately; err buffer cleared; a fresh go completes a normal pass.

Source files
------------

// File: rtl/sf_pkg.sv
// Shared definitions for the softmax feeder: data width, default sizing
// and the controller state encoding.
package sf_pkg;

  localparam int Q_W       = 32;  // Q16.16 signed fixed point
  localparam int N_DEF     = 4;   // number of classes
  localparam int IDX_W_DEF = 3;   // index width, 2**IDX_W_DEF > N_DEF

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD_SEND,
    S_FWD_GAP,
    S_WAIT_MAX,
    S_BP_WAIT,
    S_BP_ACK,
    S_DONE
  } state_e;

endpackage

// File: rtl/softmax_feeder_if.sv
// Feeder <-> softmax bus: forward word stream, argmax return and
// backprop error stream.
interface softmax_feeder_if
  import sf_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = Q_W
);

  logic [DATA_W-1:0] sf_input;
  logic [IDX_W-1:0]  sf_input_idx;
  logic              start;
  logic              backprop_ctrl;
  logic [IDX_W-1:0]  expected_label;
  logic              in_ready;
  logic              max_ready;
  logic [IDX_W-1:0]  max;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [DATA_W-1:0] out_data;

  // Feeder side
  modport master (
    output sf_input, sf_input_idx, start, backprop_ctrl, expected_label,
    input  in_ready, max_ready, max, out_ready, out_idx, out_data
  );

  // Softmax side
  modport slave (
    input  sf_input, sf_input_idx, start, backprop_ctrl, expected_label,
    output in_ready, max_ready, max, out_ready, out_idx, out_data
  );

endinterface

// File: rtl/sf_regbuf.sv
// N x DATA_W register file: one synchronous write port, one combinational
// read port (reads 0 outside 0..N-1), cleared by reset.
module sf_regbuf #(
  parameter int N      = 4,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int AW = $clog2(N);

  logic [DATA_W-1:0] mem_q [N];
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic              wr_in_range;
  logic              rd_in_range;

  assign waddr       = waddr_i[AW-1:0];
  assign raddr       = raddr_i[AW-1:0];
  assign wr_in_range = (waddr_i < IDX_W'(N));
  assign rd_in_range = (raddr_i < IDX_W'(N));

  // Storage: clear on reset, write only in-range addresses.
  // NOTE: every entry is reset because the buffers must read back 0 after
  // reset; a RAM-style array without reset would not guarantee that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (we_i && wr_in_range) begin
      mem_q[waddr] <= wdata_i;
    end
  end

  // Combinational read, zero for out-of-range indices.
  assign rdata_o = rd_in_range ? mem_q[raddr] : '0;

endmodule

// File: rtl/softmax_feeder.sv
// Buffers N logits, streams them into softmax with a one-cycle start gap
// between words, captures the argmax, then collects the backprop error
// vector into a readable buffer.
module softmax_feeder
  import sf_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = Q_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              go,
  input  logic [IDX_W-1:0]  label_in,
  input  logic [IDX_W-1:0]  err_rd_idx,
  output logic [DATA_W-1:0] err_rd_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  pred,
  softmax_feeder_if.master  sf
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] pred_q, pred_d;
  logic [IDX_W-1:0] label_q, label_d;
  logic             bp_q, bp_d;
  logic             logit_we;
  logic             err_we;

  // Logits are only writable while idle so a pass never sees them change.
  assign logit_we = (state_q == S_IDLE) && ld_valid;
  // Backprop words are captured only once the feeder signals ready.
  assign err_we   = (state_q == S_BP_ACK) && sf.out_ready;

  sf_regbuf #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_logit (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (logit_we),
    .waddr_i (ld_idx),
    .wdata_i (ld_data),
    .raddr_i (idx_q),
    .rdata_o (sf.sf_input)
  );

  sf_regbuf #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W)) u_err (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (err_we),
    .waddr_i (sf.out_idx),
    .wdata_i (sf.out_data),
    .raddr_i (err_rd_idx),
    .rdata_o (err_rd_data)
  );

  // Next-state and register updates for the pass sequencer.
  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pred_d  = pred_q;
    label_d = label_q;
    bp_d    = bp_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          label_d = label_in;
          idx_d   = '0;
          state_d = S_FWD_SEND;
        end
      end
      S_FWD_SEND: begin
        if (sf.in_ready) begin
          if (idx_q == LAST) begin
            state_d = S_WAIT_MAX;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FWD_GAP;
          end
        end
      end
      S_FWD_GAP:  state_d = S_FWD_SEND;
      S_WAIT_MAX: begin
        if (sf.max_ready) begin
          pred_d  = sf.max;
          bp_d    = 1'b1;
          state_d = S_BP_WAIT;
        end
      end
      S_BP_WAIT: begin
        if (sf.out_ready) state_d = S_BP_ACK;
      end
      S_BP_ACK: begin
        if (sf.out_ready && (sf.out_idx == LAST)) begin
          bp_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts a pass immediately.
  // NOTE: non-blocking assignments so all registers update together from
  // the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pred_q  <= '0;
      label_q <= '0;
      bp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pred_q  <= pred_d;
      label_q <= label_d;
      bp_q    <= bp_d;
    end
  end

  assign sf.sf_input_idx   = idx_q;
  assign sf.start          = (state_q == S_FWD_SEND) || (state_q == S_BP_ACK);
  assign sf.backprop_ctrl  = bp_q;
  assign sf.expected_label = label_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign pred              = pred_q;

endmodule

// File: tb/tb_softmax_feeder.sv
// Directed bench for softmax_feeder: reset, forward streaming with and
// without stalls, argmax capture, backprop collection, ignored inputs
// and reset mid-pass.
module tb_softmax_feeder;

  localparam int N      = 4;
  localparam int IDX_W  = 3;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_valid;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;
  logic              go;
  logic [IDX_W-1:0]  label_in;
  logic [IDX_W-1:0]  err_rd_idx;
  logic [DATA_W-1:0] err_rd_data;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  pred;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] logits [N] = '{32'h0000_8000, 32'h0001_8F00,
                                    32'h0002_9E00, 32'h0003_AD00};
  logic [DATA_W-1:0] errs   [N] = '{32'hFFFF_8000, 32'h0000_0100,
                                    32'h0000_0200, 32'h0000_0300};

  softmax_feeder_if #(.IDX_W(IDX_W), .DATA_W(DATA_W)) sfi ();

  softmax_feeder #(.N(N), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_idx      (ld_idx),
    .ld_data     (ld_data),
    .go          (go),
    .label_in    (label_in),
    .err_rd_idx  (err_rd_idx),
    .err_rd_data (err_rd_data),
    .busy        (busy),
    .done        (done),
    .pred        (pred),
    .sf          (sfi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_logits(input logic [DATA_W-1:0] base);
    for (int i = 0; i < N; i++) begin
      ld_valid = 1'b1;
      ld_idx   = IDX_W'(i);
      ld_data  = logits[i] + base;
      tick();
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sfi.start, sfi.backprop_ctrl, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000",
               {sfi.start, sfi.backprop_ctrl, busy, done});
    end
    checks++;
    if ({pred, sfi.expected_label, sfi.sf_input_idx} !== '0 || sfi.sf_input !== '0) begin
      failures++;
      $display("FAIL reset_data: pred=%h label=%h idx=%h sf_input=%h want 0",
               pred, sfi.expected_label, sfi.sf_input_idx, sfi.sf_input);
    end
    err_rd_idx = 3'd2;
    #1;
    checks++;
    if (err_rd_data !== '0) begin
      failures++;
      $display("FAIL reset_err: got %h want 0", err_rd_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Full-speed forward pass: word i visible in FWD_SEND, start low in gaps.
  task automatic test_forward();
    label_in = 3'd1;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (busy !== 1'b1 || sfi.expected_label !== 3'd1) begin
      failures++;
      $display("FAIL fwd_go: busy=%b label=%h want 1/1", busy, sfi.expected_label);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sfi.start !== 1'b1 || sfi.sf_input_idx !== IDX_W'(i) || sfi.sf_input !== logits[i]) begin
        failures++;
        $display("FAIL fwd_word%0d: start=%b idx=%0d data=%h want 1/%0d/%h",
                 i, sfi.start, sfi.sf_input_idx, sfi.sf_input, i, logits[i]);
      end
      tick();
      if (i < N - 1) begin
        checks++;
        if (sfi.start !== 1'b0) begin
          failures++;
          $display("FAIL fwd_gap%0d: start=%b want 0", i, sfi.start);
        end
        tick();
      end
    end
    checks++;
    if (sfi.start !== 1'b0 || busy !== 1'b1 || sfi.backprop_ctrl !== 1'b0) begin
      failures++;
      $display("FAIL fwd_wait_max: start=%b busy=%b bp=%b want 0/1/0",
               sfi.start, busy, sfi.backprop_ctrl);
    end
  endtask

  // go/ld_valid while waiting for argmax must change nothing.
  task automatic test_ignored_midpass();
    go       = 1'b1;
    label_in = 3'd2;
    ld_valid = 1'b1;
    ld_idx   = 3'd0;
    ld_data  = 32'hDEAD_BEEF;
    tick();
    go       = 1'b0;
    ld_valid = 1'b0;
    checks++;
    if (sfi.expected_label !== 3'd1 || sfi.start !== 1'b0 || sfi.backprop_ctrl !== 1'b0) begin
      failures++;
      $display("FAIL midpass_ignore: label=%h start=%b bp=%b want 1/0/0",
               sfi.expected_label, sfi.start, sfi.backprop_ctrl);
    end
  endtask

  task automatic test_max(input logic [IDX_W-1:0] m);
    sfi.max_ready = 1'b1;
    sfi.max       = m;
    tick();
    sfi.max_ready = 1'b0;
    checks++;
    if (pred !== m || sfi.backprop_ctrl !== 1'b1 || sfi.start !== 1'b0) begin
      failures++;
      $display("FAIL max_capture: pred=%h bp=%b start=%b want %h/1/0",
               pred, sfi.backprop_ctrl, sfi.start, m);
    end
  endtask

  // Backprop stream with an out-of-range index injected mid-stream.
  task automatic test_backprop();
    logic [IDX_W-1:0]  seq_idx  [5] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd3};
    logic [DATA_W-1:0] seq_data [5];
    seq_data = '{errs[0], errs[1], 32'h0BAD_0BAD, errs[2], errs[3]};
    sfi.out_ready = 1'b1;
    sfi.out_idx   = seq_idx[0];
    sfi.out_data  = seq_data[0];
    tick();
    checks++;
    if (sfi.start !== 1'b1 || sfi.backprop_ctrl !== 1'b1) begin
      failures++;
      $display("FAIL bp_ack_entry: start=%b bp=%b want 1/1", sfi.start, sfi.backprop_ctrl);
    end
    for (int j = 0; j < 5; j++) begin
      sfi.out_idx  = seq_idx[j];
      sfi.out_data = seq_data[j];
      tick();
      if (j < 4) begin
        checks++;
        if (done !== 1'b0 || sfi.start !== 1'b1) begin
          failures++;
          $display("FAIL bp_word%0d: done=%b start=%b want 0/1", j, done, sfi.start);
        end
      end
    end
    sfi.out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || sfi.backprop_ctrl !== 1'b0 || sfi.start !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: done=%b busy=%b bp=%b start=%b want 1/1/0/0",
               done, busy, sfi.backprop_ctrl, sfi.start);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle: done=%b busy=%b want 0/0", done, busy);
    end
    for (int i = 0; i < N; i++) begin
      err_rd_idx = IDX_W'(i);
      #1;
      checks++;
      if (err_rd_data !== errs[i]) begin
        failures++;
        $display("FAIL err_read%0d: got %h want %h", i, err_rd_data, errs[i]);
      end
    end
    err_rd_idx = 3'd5;
    #1;
    checks++;
    if (err_rd_data !== '0) begin
      failures++;
      $display("FAIL err_read_oob: got %h want 0", err_rd_data);
    end
  endtask

  task automatic test_max_in_idle();
    sfi.max_ready = 1'b1;
    sfi.max       = 3'd1;
    tick();
    sfi.max_ready = 1'b0;
    checks++;
    if (pred !== 3'd3 || busy !== 1'b0 || sfi.backprop_ctrl !== 1'b0) begin
      failures++;
      $display("FAIL max_idle: pred=%h busy=%b bp=%b want 3/0/0",
               pred, busy, sfi.backprop_ctrl);
    end
  endtask

  // Second pass stalls word 2 for five cycles, then is reset during BP_ACK.
  task automatic test_stall_and_reset();
    label_in = 3'd2;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sfi.start !== 1'b1 || sfi.sf_input_idx !== IDX_W'(i) || sfi.sf_input !== logits[i]) begin
        failures++;
        $display("FAIL stall_word%0d: start=%b idx=%0d data=%h want 1/%0d/%h",
                 i, sfi.start, sfi.sf_input_idx, sfi.sf_input, i, logits[i]);
      end
      if (i == 2) begin
        sfi.in_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          checks++;
          if (sfi.start !== 1'b1 || sfi.sf_input_idx !== 3'd2 || sfi.sf_input !== logits[2]) begin
            failures++;
            $display("FAIL stall_hold%0d: start=%b idx=%0d data=%h want 1/2/%h",
                     s, sfi.start, sfi.sf_input_idx, sfi.sf_input, logits[2]);
          end
        end
        sfi.in_ready = 1'b1;
      end
      tick();
      if (i < N - 1) tick();
    end
    checks++;
    if (sfi.start !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_wait_max: start=%b busy=%b want 0/1", sfi.start, busy);
    end
    test_max(3'd2);
    sfi.out_ready = 1'b1;
    sfi.out_idx   = 3'd0;
    sfi.out_data  = 32'h0000_1234;
    tick();
    tick();
    err_rd_idx = 3'd0;
    #1;
    checks++;
    if (err_rd_data !== 32'h0000_1234 || sfi.start !== 1'b1) begin
      failures++;
      $display("FAIL bp_partial: err0=%h start=%b want 00001234/1", err_rd_data, sfi.start);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sfi.start, sfi.backprop_ctrl, busy, done} !== 4'b0000 || pred !== '0
        || sfi.expected_label !== '0 || sfi.sf_input !== '0) begin
      failures++;
      $display("FAIL async_reset: ctrl=%b pred=%h label=%h sf_input=%h want 0",
               {sfi.start, sfi.backprop_ctrl, busy, done}, pred,
               sfi.expected_label, sfi.sf_input);
    end
    checks++;
    if (err_rd_data !== '0) begin
      failures++;
      $display("FAIL reset_err_clear0: got %h want 0", err_rd_data);
    end
    err_rd_idx = 3'd1;
    #1;
    checks++;
    if (err_rd_data !== '0) begin
      failures++;
      $display("FAIL reset_err_clear1: got %h want 0", err_rd_data);
    end
    sfi.out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // After reset a fresh pass runs end to end with one done pulse.
  task automatic test_after_reset();
    int n_done;
    load_logits(32'h0000_0010);
    label_in = 3'd3;
    go = 1'b1;
    tick();
    go = 1'b0;
    checks++;
    if (sfi.sf_input !== logits[0] + 32'h10 || sfi.start !== 1'b1) begin
      failures++;
      $display("FAIL fresh_word0: data=%h start=%b want %h/1",
               sfi.sf_input, sfi.start, logits[0] + 32'h10);
    end
    repeat (2 * N - 1) tick();
    test_max(3'd0);
    sfi.out_ready = 1'b1;
    sfi.out_idx   = 3'd0;
    sfi.out_data  = errs[3];
    tick();
    for (int i = 0; i < N; i++) begin
      sfi.out_idx  = IDX_W'(i);
      sfi.out_data = errs[N - 1 - i];
      tick();
    end
    sfi.out_ready = 1'b0;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fresh_done: pulses=%0d busy=%b want 1/0", n_done, busy);
    end
    err_rd_idx = 3'd1;
    #1;
    checks++;
    if (err_rd_data !== errs[2]) begin
      failures++;
      $display("FAIL fresh_err1: got %h want %h", err_rd_data, errs[2]);
    end
  endtask

  initial begin
    ld_valid      = 1'b0;
    ld_idx        = '0;
    ld_data       = '0;
    go            = 1'b0;
    label_in      = '0;
    err_rd_idx    = '0;
    sfi.in_ready  = 1'b1;
    sfi.max_ready = 1'b0;
    sfi.max       = '0;
    sfi.out_ready = 1'b0;
    sfi.out_idx   = '0;
    sfi.out_data  = '0;

    test_reset();
    load_logits('0);
    test_forward();
    test_ignored_midpass();
    test_max(3'd3);
    test_backprop();
    test_max_in_idle();
    test_stall_and_reset();
    test_after_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
